// File: rtl/fixed_pkg.sv
// fixed_pkg: shared types and constants for the Q31.32 fixed-point datapath.
//   FIXED_WIDTH / FIXED_FRAC : word width and fractional bit count
//   fixed_t                  : 64-bit two's-complement Q31.32 word
//   FIXED_MAX_POS/NEG        : symmetric saturation limits (-2^63 never produced)
//   div_state_t              : divider FSM states
package fixed_pkg;

    localparam int FIXED_WIDTH = 64;
    localparam int FIXED_FRAC  = 32;

    typedef logic [FIXED_WIDTH-1:0] fixed_t;

    localparam fixed_t FIXED_MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam fixed_t FIXED_MAX_NEG = 64'h8000_0000_0000_0001;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_magnitude.sv
// fixed_magnitude: combinational two's-complement absolute value.
//   val_i : signed Q31.32 word
//   mag_o : unsigned magnitude; -2^63 maps to 2^63 (fits in 64 unsigned bits)
module fixed_magnitude
    import fixed_pkg::*;
(
    input  fixed_t                 val_i,
    output logic [FIXED_WIDTH-1:0] mag_o
);

    assign mag_o = val_i[FIXED_WIDTH-1] ? (~val_i + 64'd1) : val_i;

endmodule

// File: rtl/fixed_divider.sv
// fixed_divider: sequential signed Q31.32 divider, c = a / b, one quotient bit
// per cycle (restoring division on magnitudes, sign applied at the end).
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/in_ready: operand handshake (in_ready only in IDLE)
//   a, b             : dividend, divisor (sampled only at accept)
//   out_valid/out_ready : result handshake, result held until accepted
//   c                : quotient, saturated on overflow / divide by zero
//   ovf, dz          : overflow and divide-by-zero flags
// Build option: define FIXED_DIVIDER_ROUND_EN for round-half-away-from-zero
// (one extra guard-bit iteration); default build truncates toward zero.
module fixed_divider
    import fixed_pkg::*;
#(
    parameter int WIDTH = FIXED_WIDTH,
    parameter int FRAC  = FIXED_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             ovf,
    output logic             dz
);

    localparam int ITER = WIDTH + FRAC;
`ifdef FIXED_DIVIDER_ROUND_EN
    // Extra iteration produces the guard bit in quo_q[0].
    localparam int NIT = ITER + 1;
`else
    localparam int NIT = ITER;
`endif
    localparam int CW = $clog2(NIT + 1);

    div_state_t       state_q, state_d;
    logic             sign_q, sign_d;
    logic             bz_q, bz_d;           // divisor was zero
    logic [WIDTH-1:0] magb_q, magb_d;
    logic [NIT-1:0]   dvd_q, dvd_d;         // dividend, consumed MSB-first
    logic [WIDTH-1:0] rem_q, rem_d;         // always < |b| <= 2^63
    logic [NIT-1:0]   quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_sh;
    logic [NIT-1:0]   mag_fin;
    logic [WIDTH-1:0] mag_lo;
    logic             ovf_fin;

    fixed_magnitude u_mag_a (.val_i(a), .mag_o(mag_a));
    fixed_magnitude u_mag_b (.val_i(b), .mag_o(mag_b));

    // Remainder may briefly reach 2*|b|-1 after the shift, hence one extra bit.
    assign rem_sh = {rem_q, dvd_q[NIT-1]};

`ifdef FIXED_DIVIDER_ROUND_EN
    // Adding the guard bit to the magnitude rounds half away from zero.
    assign mag_fin = {1'b0, quo_q[NIT-1:1]} + NIT'(quo_q[0]);
`else
    assign mag_fin = quo_q;
`endif
    assign mag_lo  = mag_fin[WIDTH-1:0];
    assign ovf_fin = |mag_fin[NIT-1:WIDTH-1];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = ov_q;
    assign c         = c_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        bz_d    = bz_q;
        magb_d  = magb_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    bz_d    = (b == '0);
                    magb_d  = mag_b;
                    dvd_d   = {mag_a, {(NIT-WIDTH){1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(NIT - 1);
                    state_d = (b == '0) ? FINAL : CALC;
                end
            end
            CALC: begin
                dvd_d = dvd_q << 1;
                if (rem_sh >= {1'b0, magb_q}) begin
                    // True difference is < |b|, so the low WIDTH bits are exact.
                    rem_d = rem_sh[WIDTH-1:0] - magb_q;
                    quo_d = {quo_q[NIT-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[NIT-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FINAL;
            end
            FINAL: begin
                dz_d  = 1'b0;
                ovf_d = 1'b0;
                if (bz_q) begin
                    // b == 0 so sign_q is the sign of a; dvd_q still holds |a|.
                    dz_d = 1'b1;
                    if (dvd_q == '0)  c_d = '0;
                    else if (sign_q)  c_d = FIXED_MAX_NEG;
                    else              c_d = FIXED_MAX_POS;
                end else if (ovf_fin) begin
                    ovf_d = 1'b1;
                    c_d   = sign_q ? FIXED_MAX_NEG : FIXED_MAX_POS;
                end else if (mag_lo == '0) begin
                    c_d = '0;
                end else begin
                    c_d = sign_q ? (~mag_lo + 1'b1) : mag_lo;
                end
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            bz_q    <= 1'b0;
            magb_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            bz_q    <= bz_d;
            magb_q  <= magb_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_fixed_divider.sv
// Directed, table-driven bench for fixed_divider plus hand-written
// backpressure and mid-operation reset sequences.
module tb_fixed_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] c;
    logic        ovf;
    logic        dz;

    fixed_divider dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c        (c),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 clk = ~clk;

`ifdef FIXED_DIVIDER_ROUND_EN
    localparam int    LAT_N    = 99;
    localparam [63:0] TWO_THRD = 64'h0000_0000_AAAA_AAAB;
    localparam [63:0] MTWO_THR = 64'hFFFF_FFFF_5555_5555;
`else
    localparam int    LAT_N    = 98;
    localparam [63:0] TWO_THRD = 64'h0000_0000_AAAA_AAAA;
    localparam [63:0] MTWO_THR = 64'hFFFF_FFFF_5555_5556;
`endif
    localparam int    LAT_Z = 2;
    localparam [63:0] MPOS  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam [63:0] MNEG  = 64'h8000_0000_0000_0001;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Launch one divide, wait (bounded) for out_valid, return result and latency.
    task automatic run_div(input logic [63:0] va, input logic [63:0] vb,
                           output logic [63:0] rc, output logic rovf,
                           output logic rdz, output int lat);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        rc   = c;
        rovf = ovf;
        rdz  = dz;
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rc, c0;
        logic        rovf, rdz;
        int          lat;

        vecs[0]  = '{64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, 1'b0, 1'b0, LAT_N};
        vecs[1]  = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0004_0000_0000, 64'hFFFF_FFFF_C000_0000, 1'b0, 1'b0, LAT_N};
        vecs[2]  = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFD_0000_0000, 64'h0,                   1'b0, 1'b0, LAT_N};
        vecs[3]  = '{64'h0000_0002_0000_0000, 64'h0000_0003_0000_0000, TWO_THRD,                1'b0, 1'b0, LAT_N};
        vecs[4]  = '{64'hFFFF_FFFE_0000_0000, 64'h0000_0003_0000_0000, MTWO_THR,                1'b0, 1'b0, LAT_N};
        vecs[5]  = '{64'h0000_0005_0000_0000, 64'h0,                   MPOS,                    1'b0, 1'b1, LAT_Z};
        vecs[6]  = '{64'hFFFF_FFFB_0000_0000, 64'h0,                   MNEG,                    1'b0, 1'b1, LAT_Z};
        vecs[7]  = '{64'h0,                   64'h0,                   64'h0,                   1'b0, 1'b1, LAT_Z};
        vecs[8]  = '{64'h4000_0000_0000_0000, 64'h0000_0000_0000_0001, MPOS,                    1'b1, 1'b0, LAT_N};
        vecs[9]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000, MPOS,                    1'b1, 1'b0, LAT_N};
        vecs[10] = '{64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, MNEG,                    1'b1, 1'b0, LAT_N};
        vecs[11] = '{64'h0000_0007_0000_0000, 64'h0000_0002_0000_0000, 64'h0000_0003_8000_0000, 1'b0, 1'b0, LAT_N};
        vecs[12] = '{64'hFFFF_FFF9_0000_0000, 64'h0000_0002_0000_0000, 64'hFFFF_FFFC_8000_0000, 1'b0, 1'b0, LAT_N};
        vecs[13] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0003_0000_0000, 64'h0,                   1'b0, 1'b0, LAT_N};

        // Reset state
        #12;
        check("rst.in_ready",  {63'd0, in_ready},  64'd1);
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.c",         c,                  64'd0);
        check("rst.flags",     {62'd0, ovf, dz},   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_div(vecs[i].a, vecs[i].b, rc, rovf, rdz, lat);
            check($sformatf("v%0d.c", i),   rc,                 vecs[i].c);
            check($sformatf("v%0d.ovf", i), {63'd0, rovf},      {63'd0, vecs[i].ovf});
            check($sformatf("v%0d.dz", i),  {63'd0, rdz},       {63'd0, vecs[i].dz});
            check($sformatf("v%0d.lat", i), 64'(lat),           64'(vecs[i].lat));
            accept_out();
            check($sformatf("v%0d.idle", i), {62'd0, out_valid, in_ready}, 64'd1);
        end

        // Backpressure: result held, in_valid pulses ignored while in DONE.
        run_div(64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, c0, rovf, rdz, lat);
        check("bp.c0", c0, 64'h0000_0003_0000_0000);
        for (int k = 0; k < 10; k++) begin
            a        = 64'h0000_0009_0000_0000 + 64'(k);
            b        = (k % 2 == 0) ? 64'h0 : 64'h0000_0001_0000_0000;
            in_valid = k[0];
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.hold", k),
                  {61'd0, out_valid, in_ready, dz}, 64'b100);
            check($sformatf("bp%0d.c", k), c, c0);
        end
        in_valid = 1'b0;
        accept_out();
        check("bp.idle", {62'd0, out_valid, in_ready}, 64'd1);
        run_div(64'hFFFF_FFFF_0000_0000, 64'h0000_0004_0000_0000, rc, rovf, rdz, lat);
        check("bp.next.c",   rc, 64'hFFFF_FFFF_C000_0000);
        check("bp.next.lat", 64'(lat), 64'(LAT_N));
        accept_out();

        // Reset during CALC iteration 40 abandons the divide.
        a        = 64'h0000_0002_0000_0000;
        b        = 64'h0000_0003_0000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid.rst.vld_rdy", {62'd0, out_valid, in_ready}, 64'd1);
        check("mid.rst.c",       c, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_div(64'h0000_0006_0000_0000, 64'h0000_0002_0000_0000, rc, rovf, rdz, lat);
        check("mid.next.c",     rc, 64'h0000_0003_0000_0000);
        check("mid.next.flags", {62'd0, rovf, rdz}, 64'd0);
        check("mid.next.lat",   64'(lat), 64'(LAT_N));
        accept_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
